// File: rtl/micro_udp_engine_pkg.sv
// Shared types and constants for the micro UDP engine.
// Ethernet framing constants and the RX demux state encoding.
package micro_udp_engine_pkg;

    localparam int ETH_HDR_BYTES = 14;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
    localparam logic [15:0] ETHERTYPE_IPV6 = 16'h86DD;

    typedef struct packed {
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [15:0] ethertype;
    } eth_frame_hdr_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FWD,
        S_DROP
    } rx_state_e;

endpackage

// File: rtl/micro_udp_engine_byte_realign.sv
// Byte realigner: holds the tail of the previous beat and splices it
// ahead of the head of the current beat, plus empty/flush arithmetic.
module micro_udp_engine_byte_realign #(
    parameter int DATA_W      = 256,
    parameter int SHIFT_BYTES = 14,
    localparam int B          = DATA_W / 8,
    localparam int EW         = $clog2(B)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [DATA_W-1:0] in_data,
    input  logic [EW-1:0]     in_empty,
    output logic [DATA_W-1:0] cat_data,
    output logic [DATA_W-1:0] flush_data,
    output logic              tail_fits,
    output logic [EW-1:0]     last_empty,
    output logic [EW-1:0]     flush_empty
);

    localparam int R  = B - SHIFT_BYTES;
    localparam int RW = 8 * R;
    localparam int HW = 8 * SHIFT_BYTES;
    localparam logic [EW-1:0] R_E = EW'(R);
    localparam logic [EW-1:0] H_E = EW'(SHIFT_BYTES);

    logic [RW-1:0] rest;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rest <= '0;
        end else if (load) begin
            rest <= in_data[RW-1:0];
        end
    end

    assign cat_data   = {rest, in_data[DATA_W-1 -: HW]};
    assign flush_data = {rest, {HW{1'b0}}};

    // Last beat fits in the spliced beat when at most SHIFT_BYTES are valid.
    assign tail_fits   = (in_empty >= R_E);
    assign last_empty  = in_empty - R_E;
    assign flush_empty = in_empty + H_E;

endmodule

// File: rtl/micro_udp_engine_eth_rx_demux.sv
// Ethernet RX front end: strips the header, realigns the payload and
// steers frames to ethertype channels, with drop/error/runt counters.
module micro_udp_engine_eth_rx_demux
    import micro_udp_engine_pkg::*;
#(
    parameter int                   DATA_W    = 256,
    parameter int                   NUM_CH    = 2,
    parameter logic [NUM_CH*16-1:0] ETH_TYPES = {ETHERTYPE_ARP, ETHERTYPE_IPV4},
    localparam int                  EW        = $clog2(DATA_W / 8)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DATA_W-1:0]    in_data,
    input  logic [EW-1:0]        in_empty,
    input  logic                 in_startofpacket,
    input  logic                 in_endofpacket,
    input  logic                 in_valid,
    input  logic                 in_error,
    input  logic                 in_fcs_error,
    output logic [DATA_W-1:0]    out_data,
    output logic [EW-1:0]        out_empty,
    output logic                 out_startofpacket,
    output logic                 out_endofpacket,
    output logic                 out_error,
    output logic [NUM_CH-1:0]    out_valid,
    output logic [NUM_CH*32-1:0] cnt_frames,
    output logic [31:0]          cnt_drop_type,
    output logic [31:0]          cnt_error,
    output logic [31:0]          cnt_runt
);

    localparam int CHW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ETYPE_LSB = DATA_W - $bits(eth_frame_hdr_t);
    localparam logic [EW-1:0] H_E = EW'(ETH_HDR_BYTES);

    logic [DATA_W-1:0] cat_data;
    logic [DATA_W-1:0] flush_data;
    logic              tail_fits;
    logic [EW-1:0]     last_empty;
    logic [EW-1:0]     flush_empty;

    micro_udp_engine_byte_realign #(
        .DATA_W      (DATA_W),
        .SHIFT_BYTES (ETH_HDR_BYTES)
    ) u_realign (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (in_valid),
        .in_data     (in_data),
        .in_empty    (in_empty),
        .cat_data    (cat_data),
        .flush_data  (flush_data),
        .tail_fits   (tail_fits),
        .last_empty  (last_empty),
        .flush_empty (flush_empty)
    );

    rx_state_e          state, state_n;
    logic [CHW-1:0]     ch, ch_n;
    logic               first, first_n;
    logic               erracc, erracc_n;
    logic               pend, pend_n;
    logic [CHW-1:0]     pend_ch, pend_ch_n;
    logic               pend_sop, pend_sop_n;
    logic               pend_err, pend_err_n;
    logic [EW-1:0]      pend_empty, pend_empty_n;

    logic               emit;
    logic [CHW-1:0]     emit_ch;
    logic [NUM_CH-1:0]  ov_n;
    logic [DATA_W-1:0]  od_n;
    logic [EW-1:0]      oe_n;
    logic               osop_n, oeop_n, oerr_n;

    logic               frm_inc, drop_inc, runt_inc, err_a, err_b;
    logic [CHW-1:0]     frm_ch;
    logic               take_sop, last_err;

    logic [15:0]        ethertype;
    logic               hit;
    logic [CHW-1:0]     hit_idx;

    assign ethertype = in_data[ETYPE_LSB +: 16];

    // Scan downwards so the lowest matching channel wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ethertype == ETH_TYPES[16*i +: 16]) begin
                hit     = 1'b1;
                hit_idx = CHW'(i);
            end
        end
    end

    always_comb begin
        state_n      = state;
        ch_n         = ch;
        first_n      = first;
        erracc_n     = erracc;
        pend_n       = 1'b0;
        pend_ch_n    = pend_ch;
        pend_sop_n   = pend_sop;
        pend_err_n   = pend_err;
        pend_empty_n = pend_empty;
        emit         = 1'b0;
        emit_ch      = ch;
        od_n         = cat_data;
        oe_n         = '0;
        osop_n       = 1'b0;
        oeop_n       = 1'b0;
        oerr_n       = 1'b0;
        frm_inc      = 1'b0;
        frm_ch       = ch;
        drop_inc     = 1'b0;
        runt_inc     = 1'b0;
        err_a        = 1'b0;
        err_b        = 1'b0;
        take_sop     = 1'b0;
        last_err     = erracc | in_error | in_fcs_error;

        // Pending flush only exists in S_IDLE, where no other beat is emitted.
        if (pend) begin
            emit    = 1'b1;
            emit_ch = pend_ch;
            od_n    = flush_data;
            oe_n    = pend_empty;
            osop_n  = pend_sop;
            oeop_n  = 1'b1;
            oerr_n  = pend_err;
        end

        if (in_valid) begin
            unique case (state)
                S_IDLE: take_sop = in_startofpacket;
                S_FWD: begin
                    if (in_startofpacket) begin
                        emit     = 1'b1;
                        od_n     = flush_data;
                        oe_n     = H_E;
                        osop_n   = first;
                        oeop_n   = 1'b1;
                        oerr_n   = 1'b1;
                        err_a    = 1'b1;
                        take_sop = 1'b1;
                        state_n  = S_IDLE;
                    end else begin
                        emit     = 1'b1;
                        osop_n   = first;
                        first_n  = 1'b0;
                        erracc_n = erracc | in_error;
                        if (in_endofpacket) begin
                            state_n = S_IDLE;
                            frm_inc = 1'b1;
                            err_a   = last_err;
                            if (tail_fits) begin
                                oeop_n = 1'b1;
                                oe_n   = last_empty;
                                oerr_n = last_err;
                            end else begin
                                pend_n       = 1'b1;
                                pend_ch_n    = ch;
                                pend_sop_n   = 1'b0;
                                pend_err_n   = last_err;
                                pend_empty_n = flush_empty;
                            end
                        end
                    end
                end
                S_DROP: begin
                    if (in_startofpacket) begin
                        take_sop = 1'b1;
                    end else if (in_endofpacket) begin
                        state_n = S_IDLE;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end

        if (take_sop) begin
            first_n  = 1'b1;
            erracc_n = in_error;
            ch_n     = hit_idx;
            if (!hit) begin
                drop_inc = 1'b1;
                state_n  = in_endofpacket ? S_IDLE : S_DROP;
            end else if (!in_endofpacket) begin
                state_n = S_FWD;
            end else begin
                state_n = S_IDLE;
                err_b   = in_error | in_fcs_error;
                if (tail_fits) begin
                    runt_inc = 1'b1;
                end else begin
                    frm_inc      = 1'b1;
                    frm_ch       = hit_idx;
                    pend_n       = 1'b1;
                    pend_ch_n    = hit_idx;
                    pend_sop_n   = 1'b1;
                    pend_err_n   = in_error | in_fcs_error;
                    pend_empty_n = flush_empty;
                end
            end
        end

        ov_n = '0;
        if (emit) begin
            ov_n[emit_ch] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            ch         <= '0;
            first      <= 1'b0;
            erracc     <= 1'b0;
            pend       <= 1'b0;
            pend_ch    <= '0;
            pend_sop   <= 1'b0;
            pend_err   <= 1'b0;
            pend_empty <= '0;
        end else begin
            state      <= state_n;
            ch         <= ch_n;
            first      <= first_n;
            erracc     <= erracc_n;
            pend       <= pend_n;
            pend_ch    <= pend_ch_n;
            pend_sop   <= pend_sop_n;
            pend_err   <= pend_err_n;
            pend_empty <= pend_empty_n;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid         <= '0;
            out_data          <= '0;
            out_empty         <= '0;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
            out_error         <= 1'b0;
        end else begin
            out_valid         <= ov_n;
            out_data          <= od_n;
            out_empty         <= oe_n;
            out_startofpacket <= osop_n;
            out_endofpacket   <= oeop_n;
            out_error         <= oerr_n;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_frames    <= '0;
            cnt_drop_type <= '0;
            cnt_error     <= '0;
            cnt_runt      <= '0;
        end else begin
            if (frm_inc) begin
                cnt_frames[32*int'(frm_ch) +: 32] <=
                    cnt_frames[32*int'(frm_ch) +: 32] + 32'd1;
            end
            cnt_drop_type <= cnt_drop_type + 32'(drop_inc);
            cnt_error     <= cnt_error + 32'(err_a) + 32'(err_b);
            cnt_runt      <= cnt_runt + 32'(runt_inc);
        end
    end

endmodule

// File: tb/tb_micro_udp_engine_eth_rx_demux.sv
// Scoreboard bench for the Ethernet RX demux: stimulus pushes expected
// payload beats, a negedge monitor pops and compares every output beat.
module tb_micro_udp_engine_eth_rx_demux;

    localparam int DATA_W = 256;
    localparam int NUM_CH = 2;
    localparam int EW     = 5;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [DATA_W-1:0]    in_data;
    logic [EW-1:0]        in_empty;
    logic                 in_startofpacket;
    logic                 in_endofpacket;
    logic                 in_valid;
    logic                 in_error;
    logic                 in_fcs_error;
    logic [DATA_W-1:0]    out_data;
    logic [EW-1:0]        out_empty;
    logic                 out_startofpacket;
    logic                 out_endofpacket;
    logic                 out_error;
    logic [NUM_CH-1:0]    out_valid;
    logic [NUM_CH*32-1:0] cnt_frames;
    logic [31:0]          cnt_drop_type;
    logic [31:0]          cnt_error;
    logic [31:0]          cnt_runt;

    micro_udp_engine_eth_rx_demux #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_data           (in_data),
        .in_empty          (in_empty),
        .in_startofpacket  (in_startofpacket),
        .in_endofpacket    (in_endofpacket),
        .in_valid          (in_valid),
        .in_error          (in_error),
        .in_fcs_error      (in_fcs_error),
        .out_data          (out_data),
        .out_empty         (out_empty),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket),
        .out_error         (out_error),
        .out_valid         (out_valid),
        .cnt_frames        (cnt_frames),
        .cnt_drop_type     (cnt_drop_type),
        .cnt_error         (cnt_error),
        .cnt_runt          (cnt_runt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                ch;
        logic [DATA_W-1:0] data;
        logic [EW-1:0]     empty;
        logic              sop;
        logic              eop;
        logic              err;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_beats  = 0;

    logic [7:0] frm [0:127];
    int         frm_len;

    int exp_f0 = 0, exp_f1 = 0, exp_drop = 0, exp_err = 0, exp_runt = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1 && out_valid !== '0) begin
            exp_t e;
            n_checks++;
            n_beats++;
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL beat%0d: unexpected out_valid=%b", n_beats, out_valid);
            end else begin
                logic [NUM_CH-1:0] ov_exp;
                e = sbq.pop_front();
                ov_exp = '0;
                ov_exp[e.ch] = 1'b1;
                if (out_valid !== ov_exp || out_data !== e.data ||
                    out_empty !== e.empty || out_startofpacket !== e.sop ||
                    out_endofpacket !== e.eop || out_error !== e.err) begin
                    n_fail++;
                    $display("FAIL beat%0d: got v=%b sop=%b eop=%b err=%b empty=%0d data=%h want v=%b sop=%b eop=%b err=%b empty=%0d data=%h",
                             n_beats, out_valid, out_startofpacket, out_endofpacket,
                             out_error, out_empty, out_data, ov_exp, e.sop, e.eop,
                             e.err, e.empty, e.data);
                end
            end
        end
    end

    task automatic make_frame(input int len, input logic [15:0] et, input int seed);
        frm_len = len;
        for (int i = 0; i < 128; i++) frm[i] = 8'(seed + 7 * i + 1);
        frm[12] = et[15:8];
        frm[13] = et[7:0];
    endtask

    // Expected payload = frame bytes [first, last) cut into 32-byte beats.
    task automatic expect_payload(input int ch, input int first, input int last,
                                  input logic err);
        int n;
        int k;
        exp_t e;
        n = last - first;
        k = 0;
        while (k < n) begin
            e.data = '0;
            for (int b = 0; b < 32 && k + b < n; b++)
                e.data[DATA_W-1-8*b -: 8] = frm[first + k + b];
            e.ch    = ch;
            e.sop   = (k == 0);
            e.eop   = (k + 32 >= n);
            e.empty = e.eop ? EW'(32 - (n - k)) : '0;
            e.err   = e.eop ? err : 1'b0;
            sbq.push_back(e);
            k += 32;
        end
    endtask

    task automatic drive_beat(input int first, input int nbytes, input logic sop,
                              input logic eop, input logic fcs);
        in_data = '0;
        for (int b = 0; b < nbytes; b++) in_data[DATA_W-1-8*b -: 8] = frm[first + b];
        in_empty         = eop ? EW'(32 - nbytes) : '0;
        in_startofpacket = sop;
        in_endofpacket   = eop;
        in_fcs_error     = fcs;
        in_valid         = 1'b1;
        @(posedge clk);
        #1;
        in_valid         = 1'b0;
        in_startofpacket = 1'b0;
        in_endofpacket   = 1'b0;
        in_fcs_error     = 1'b0;
    endtask

    task automatic send_frame(input int ch, input logic fcs);
        int off;
        int nb;
        if (ch >= 0) expect_payload(ch, 14, frm_len, fcs);
        off = 0;
        while (off < frm_len) begin
            nb = (frm_len - off > 32) ? 32 : frm_len - off;
            drive_beat(off, nb, off == 0, off + nb >= frm_len, fcs);
            off += nb;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, ".frames0"}, 64'(cnt_frames[31:0]), 64'(exp_f0));
        chk({tag, ".frames1"}, 64'(cnt_frames[63:32]), 64'(exp_f1));
        chk({tag, ".drop"}, 64'(cnt_drop_type), 64'(exp_drop));
        chk({tag, ".error"}, 64'(cnt_error), 64'(exp_err));
        chk({tag, ".runt"}, 64'(cnt_runt), 64'(exp_runt));
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        reset_n          = 1'b0;
        in_data          = '0;
        in_empty         = '0;
        in_startofpacket = 1'b0;
        in_endofpacket   = 1'b0;
        in_valid         = 1'b0;
        in_error         = 1'b0;
        in_fcs_error     = 1'b0;
        idle(3);
        chk("reset.out_valid", 64'(out_valid), 64'd0);
        chk("reset.out_data", 64'(out_data[63:0]), 64'd0);
        chk("reset.out_flags", 64'({out_startofpacket, out_endofpacket, out_error, out_empty}), 64'd0);
        chk_counters("reset");
        reset_n = 1'b1;
        idle(2);

        // ARP 60 bytes: 32-byte sop beat then 14-byte flush, empty 18
        make_frame(60, 16'h0806, 3);
        send_frame(1, 1'b0);
        exp_f1++;
        idle(3);
        chk_counters("arp60");

        // IPv4 64 bytes: 32 + 18 bytes, flush empty 14
        make_frame(64, 16'h0800, 20);
        send_frame(0, 1'b0);
        exp_f0++;
        idle(3);

        // IPv4 42 bytes: single output beat, empty 4, no flush
        make_frame(42, 16'h0800, 40);
        send_frame(0, 1'b0);
        exp_f0++;
        idle(3);
        chk_counters("ipv4");

        // IPv6 dropped, ARP immediately after
        make_frame(60, 16'h86DD, 60);
        send_frame(-1, 1'b0);
        exp_drop++;
        make_frame(60, 16'h0806, 80);
        send_frame(1, 1'b0);
        exp_f1++;
        idle(3);
        chk_counters("drop");

        // FCS error on the last beat
        make_frame(64, 16'h0800, 100);
        send_frame(0, 1'b1);
        exp_f0++;
        exp_err++;
        idle(3);
        chk_counters("fcs");

        // Truncation: two beats of IPv4 then a new ARP sop
        make_frame(96, 16'h0800, 120);
        expect_payload(0, 14, 64, 1'b1);
        drive_beat(0, 32, 1'b1, 1'b0, 1'b0);
        drive_beat(32, 32, 1'b0, 1'b0, 1'b0);
        exp_err++;
        make_frame(60, 16'h0806, 140);
        send_frame(1, 1'b0);
        exp_f1++;
        idle(3);
        chk_counters("trunc");

        // Header-only single-beat runt
        make_frame(14, 16'h0800, 160);
        send_frame(-1, 1'b0);
        exp_runt++;
        idle(3);
        chk_counters("runt");

        // Back-to-back: IPv4 flush overlaps ARP sop beat
        make_frame(64, 16'h0800, 180);
        send_frame(0, 1'b0);
        exp_f0++;
        make_frame(60, 16'h0806, 200);
        send_frame(1, 1'b0);
        exp_f1++;
        // Single-beat 30-byte ARP: one beat sop=eop, empty 16
        make_frame(30, 16'h0806, 220);
        send_frame(1, 1'b0);
        exp_f1++;
        idle(4);
        chk_counters("b2b");

        // Reset mid-frame: output visible, then cleared asynchronously
        make_frame(128, 16'h0800, 240);
        drive_beat(0, 32, 1'b1, 1'b0, 1'b0);
        drive_beat(32, 32, 1'b0, 1'b0, 1'b0);
        chk("midframe.out_valid", 64'(out_valid), 64'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async.out_valid", 64'(out_valid), 64'd0);
        chk("async.out_data", 64'(out_data[DATA_W-1 -: 64]), 64'd0);
        exp_f0 = 0; exp_f1 = 0; exp_drop = 0; exp_err = 0; exp_runt = 0;
        chk_counters("async");
        idle(2);
        reset_n = 1'b1;
        idle(1);
        drive_beat(64, 32, 1'b0, 1'b0, 1'b0);
        drive_beat(96, 32, 1'b0, 1'b1, 1'b0);
        idle(2);
        make_frame(60, 16'h0806, 33);
        send_frame(1, 1'b0);
        exp_f1++;
        idle(4);
        chk_counters("post_reset");

        chk("scoreboard.drained", 64'(sbq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/micro_udp_engine_eth_rx_demux.md
# micro_udp_engine_eth_rx_demux

Parametrised Ethernet RX front end of the micro UDP engine. It sits between the MAC RX Avalon-ST output and the protocol blocks (ARP, IPv4, further ethertypes). It strips the 14-byte Ethernet header and re-aligns the payload to byte 0 of the output bus. It demultiplexes frames to `NUM_CH` ethertype channels, with correct `empty` handling including the extra tail beat. Errored and FCS-failed frames are flagged, unknown ethertypes are dropped, and all of these events are counted.

## Interface
- `DATA_W`, 256: bus width in bits; multiple of 8, ≥ 128. B = DATA_W/8 bytes, EW = $clog2(B).
- `NUM_CH`, 2: number of output channels.
- `ETH_TYPES`, {16'h0806, 16'h0800}: NUM_CH×16 packed; channel i matches `ETH_TYPES[16*i +: 16]` (ch0 IPv4, ch1 ARP).
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_data` in DATA_W: byte 0 in MSBs.
- `in_empty` in EW: empty bytes, meaningful on eop.
- `in_startofpacket`, `in_endofpacket`, `in_valid`, `in_error` in 1: MAC stream. No backpressure.
- `in_fcs_error` in 1: qualified by eop & valid.
- `out_data` out DATA_W, `out_empty` out EW, `out_startofpacket`, `out_endofpacket`, `out_error` out 1: shared payload bus.
- `out_valid` out NUM_CH: one-hot channel qualifier.
- `cnt_frames` out NUM_CH×32: frames forwarded per channel.
- `cnt_drop_type` out 32: frames with an unmatched ethertype.
- `cnt_error` out 32: frames with error, FCS error or truncation.
- `cnt_runt` out 32: frames with ≤ H payload-bearing bytes.

## Operation
- H = 14, R = B−H. Output beat j = in beat j bytes [H..B−1] followed by in beat j+1 bytes [0..H−1]. The rest register holds R bytes and loads only on `in_valid`.
- States:
  - S_IDLE: sop&valid → compare ethertype (bytes 12–13) against `ETH_TYPES`. The lowest matching index is latched as ch → S_FWD; no match → S_DROP and `cnt_drop_type`++.
  - S_FWD / S_DROP: eop&valid → S_IDLE.
- Last input beat has V = B−in_empty valid bytes.
  - V ≤ H: the output beat carrying the head of that beat is last; `out_empty` = H−V.
  - V > H: that output beat is full (`out_empty`=0, no eop). A flush beat follows carrying V−H bytes, eop=1, `out_empty` = in_empty+H. The flush beat uses a pending flag, not a state, so it overlaps a new sop beat without stall. A sop beat never produces output.
- Single-beat frame (sop&eop): V > H → one flush beat with sop=eop=1. V ≤ H → runt: nothing output, `cnt_runt`++, return to S_IDLE.
- `out_error` = in_error | in_fcs_error on the frame's last output beat. `cnt_error`++ once per frame. Frames are cut-through and are never retroactively dropped.
- sop while in S_FWD without a prior eop → emit one beat for the held frame: eop=1, error=1, `out_empty`=H. `cnt_error`++, then handle the new sop from S_IDLE. In S_DROP the old frame is silently discarded.
- `in_valid` low: no output, state and rest held. Valid/eop without a preceding sop in S_IDLE is ignored.
- `cnt_frames[ch]`++ on each forwarded eop. All counters are 32-bit and wrap.

## Timing
- All outputs registered. Reset values: `out_valid`=0, every other output and all counters 0, state S_IDLE, flush flag 0.
- Input beat k+1 accepted at cycle t → output beat k valid at t+1. Flush beat at t+2 when eop is at t.
- `out_valid` is never asserted in S_DROP or for runts. `out_startofpacket` is on the first emitted beat only.
- `reset_n` low mid-frame: outputs clear immediately (asynchronously). After release, input is ignored until the next sop.

## Structure
- `micro_udp_engine_pkg`: add `ETH_HDR_BYTES`=14, `ETHERTYPE_IPV4`/`ETHERTYPE_ARP`/`ETHERTYPE_IPV6`, and reuse `eth_frame_hdr_t`.
- Sub-module `micro_udp_engine_byte_realign` (DATA_W, SHIFT_BYTES): rest register, concatenation and empty/flush arithmetic. The top level holds the FSM, channel match and counters.

## Test plan
(DATA_W=256: B=32, R=18.)
- ARP 60-byte frame, beats 32+28 (empty 4) → ch1: beat 32 B sop, flush 14 B `out_empty`=18 eop; `cnt_frames[1]`=1.
- IPv4 64-byte frame (empty 0) → ch0: 32 B sop, then 18 B `out_empty`=14 eop, at t+1 and t+2.
- IPv4 42-byte frame, beats 32+10 (empty 22) → single beat sop=eop, `out_empty`=4, no flush.
- Ethertype 0x86DD frame, then ARP with sop the cycle after eop → no `out_valid` for the first; `cnt_drop_type`=1; ARP byte-exact, flush of the dropped frame absent.
- IPv4 with `in_fcs_error` on eop → `out_error`=1 on last beat, `cnt_error`=1. Sop mid-frame → truncated beat eop=1, error=1, `out_empty`=14.
- `reset_n` pulsed mid-frame → outputs 0 immediately. Next ARP frame forwarded correctly and counters restart from 0.
